// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: issues the start pulse, times the sensor's response and
// 40 data bits, verifies the checksum and holds the last good humidity/temperature.
module dht11_reader #(
  parameter int TICK_DIV     = 50,
  parameter int START_LOW_US = 18000,
  parameter int BIT1_THR_US  = 50,
  parameter int TIMEOUT_US   = 200,
  parameter int GAP_US       = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] hum,
  output logic [7:0] temp,
  output logic       err_timeout,
  output logic       err_checksum
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_WAIT_ACK, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   phase_q, phase_nx, cool_q;
  logic [39:0]   data_q, data_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          ok_q, err_to_q;
  logic [7:0]    hum_q, temp_q, sum;
  logic          tick, fall, rise, in_wait, timeout, bit_val, sum_ok, load_cool;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  // phase_nx is the elapsed-us count including the current cycle, so duration
  // compares see exactly N us after N*TICK_DIV cycles in a state.
  assign phase_nx = (phase_q == 16'hFFFF) ? phase_q : phase_q + {15'd0, tick};
  assign fall     = prev_q & ~sync2_q;
  assign rise     = ~prev_q & sync2_q;
  assign in_wait  = state_q inside {S_WAIT_ACK, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH};
  assign timeout  = in_wait && (phase_nx >= 16'(TIMEOUT_US));
  assign bit_val  = (phase_nx >= 16'(BIT1_THR_US));
  assign sum      = data_q[39:32] + data_q[31:24] + data_q[23:16] + data_q[15:8];
  assign sum_ok   = (sum == data_q[7:0]);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    load_cool = 1'b0;
    case (state_q)
      S_IDLE:      if (start && cool_q == 16'd0) begin
                     state_d = S_START_LOW;
                     cnt_d   = 6'd0;
                   end
      S_START_LOW: if (phase_nx >= 16'(START_LOW_US)) state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (fall) state_d = S_RESP_LOW;
      S_RESP_LOW:  if (rise) state_d = S_RESP_HIGH;
      S_RESP_HIGH: if (fall) state_d = S_BIT_LOW;
      S_BIT_LOW:   if (rise) state_d = S_BIT_HIGH;
      S_BIT_HIGH:  if (fall) begin
                     data_d  = {data_q[38:0], bit_val};
                     cnt_d   = cnt_q + 6'd1;
                     state_d = (cnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
                   end
      S_CHECK:     state_d = S_DONE;
      S_DONE:      begin
                     state_d   = S_IDLE;
                     load_cool = 1'b1;
                   end
      default:     state_d = S_IDLE;
    endcase
    // An expired phase overrides any edge seen in the same cycle.
    if (timeout) begin
      state_d   = S_IDLE;
      data_d    = data_q;
      cnt_d     = cnt_q;
      load_cool = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      presc_q  <= '0;
      phase_q  <= '0;
      cool_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      ok_q     <= 1'b0;
      err_to_q <= 1'b0;
      hum_q    <= '0;
      temp_q   <= '0;
    end else begin
      sync1_q  <= dht_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_to_q <= timeout;
      if (state_d != state_q) begin
        presc_q <= '0;
        phase_q <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        phase_q <= phase_nx;
      end
      if (load_cool)
        cool_q <= 16'(GAP_US);
      else if (state_q == S_IDLE && tick && cool_q != 16'd0)
        cool_q <= cool_q - 16'd1;
      if (state_q == S_CHECK) begin
        ok_q <= sum_ok;
        if (sum_ok) begin
          hum_q  <= data_q[39:32];
          temp_q <= data_q[23:16];
        end
      end
    end
  end

  assign dht_oe       = (state_q == S_START_LOW);
  assign busy         = (state_q != S_IDLE);
  assign valid        = (state_q == S_DONE) && ok_q;
  assign err_checksum = (state_q == S_DONE) && !ok_q;
  assign err_timeout  = err_to_q;
  assign hum          = hum_q;
  assign temp         = temp_q;
endmodule
